truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencer that exhaustively characterises one 3-input combinational gate of the truth-table family (for example the 0xCC gate, out = NOT in2).
- Drives the gate's in1/in2/in3 through all eight input rows in ascending order.
- Waits a programmable settling interval per row, then samples the gate output.
- Assembles the measured 8-bit truth table and compares it against an expected code.
- Sits between a test/host controller (start/abort/result) and a single DUT gate instance; one sweeper per gate.

## Interface
Parameters:
- SETTLE_CYCLES, 16, cycles each row is held before sampling; legal range 1 .. 2^CNT_W-1
- CNT_W, 16, width of the settle counter
- EXPECTED, 8'hCC, expected truth-table code; row r = {in1,in2,in3} maps to bit (7-r)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; honoured only in IDLE
- abort  input  1  cancel a sweep in progress
- in1, in2, in3  output  1 each  stimulus to DUT gate
- dut_out  input  1  DUT gate output
- busy  output  1  high in SETTLE/SAMPLE
- done  output  1  one-cycle pulse when a sweep completes (not on abort)
- table  output  8  measured truth table, bit (7-r) = dut_out sampled for row r
- mismatch  output  8  table XOR EXPECTED, valid from done onward
- pass  output  1  table == EXPECTED, valid from done onward
- pass_count  output  8  number of completed passing sweeps, saturates at 255

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset values: state IDLE, row 0, counter 0, in1/in2/in3 = 0, busy 0, done 0, table 8'h00, mismatch 8'h00, pass 0, pass_count 0.
- IDLE: {in1,in2,in3} = 3'b000.
  - start=1 and abort=0: clear table, mismatch and pass; set row=0; load counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: {in1,in2,in3} = row.
  - Counter decrements each cycle.
  - When counter = 0, go to SAMPLE.
- SAMPLE: {in1,in2,in3} still = row.
  - Write dut_out into table bit (7-row).
  - row < 7: row+1, reload counter with SETTLE_CYCLES-1, go to SETTLE.
  - row = 7: go to DONE.
- DONE: done=1 for exactly this cycle.
  - mismatch, pass and pass_count update on entry to DONE, i.e. they are valid in the DONE cycle.
  - Next state IDLE; inputs return to 000.
- table, mismatch and pass hold their values in IDLE until the next accepted start.
- abort=1 in SETTLE or SAMPLE: next cycle IDLE.
  - No done pulse; pass=0; mismatch unchanged (0); pass_count unchanged.
  - table keeps the bits captured so far.
  - A SAMPLE cycle coincident with abort still captures its bit.
- abort in IDLE or DONE: no effect; a DONE cycle still completes normally.
- start while busy or in DONE: ignored. start with abort in IDLE: abort wins, stay IDLE.
- rst mid-sweep: all state and outputs return to reset values on the next edge, including pass_count.
- pass_count increments by 1 on a passing sweep and holds at 8'hFF.

## Timing
- start sampled at edge k. First SETTLE cycle is k+1 with inputs = 000.
- Row r occupies cycles k+1+r·(SETTLE_CYCLES+1) through k+(r+1)·(SETTLE_CYCLES+1).
  - The first SETTLE_CYCLES of those cycles are SETTLE.
  - The last cycle is SAMPLE.
- done is high in cycle k+1+8·(SETTLE_CYCLES+1). Sweep latency is 8·(SETTLE_CYCLES+1)+1 cycles.
- busy is high from cycle k+1 through the last SAMPLE, and low in DONE.
- Earliest next start is accepted in the cycle after DONE.
- Input changes are registered outputs; dut_out is sampled registered in SAMPLE with no internal synchroniser, because the DUT shares clk.

## Test plan
- DUT modelled as NOT in2, SETTLE_CYCLES=4, start pulse at cycle 10 -> done high at cycle 51 only; table=8'hCC; pass=1; mismatch=8'h00; pass_count=1.
- DUT tied dut_out=1, EXPECTED=8'hCC -> table=8'hFF, mismatch=8'h33, pass=0, pass_count unchanged.
- Check each row's stimulus and hold time: with SETTLE_CYCLES=1, {in1,in2,in3} steps 000..111, each value held exactly 2 cycles; busy high for 16 cycles.
- Abort during row 3 SETTLE -> IDLE next cycle, no done, inputs 000, table bits 7..5 = captured values, bits 4..0 = 0, pass=0.
- Assert rst mid-sweep with pass_count=2 -> all outputs return to reset values next cycle. Run 256 passing sweeps -> pass_count stays 8'hFF.
- Pulse start repeatedly while busy, and assert start with abort in IDLE -> no restart, done timing unchanged (first case) / remains IDLE (second case).

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Host/gate-side signal bundle for truth_table_sweeper.
// The sweeper takes the slave view; the host controller and DUT gate together form the master.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] table_bits;
  logic [7:0] mismatch;
  logic       pass;
  logic [7:0] pass_count;

  modport master (
    output start, abort, dut_out,
    input  in1, in2, in3, busy, done, table_bits, mismatch, pass, pass_count
  );

  modport slave (
    input  start, abort, dut_out,
    output in1, in2, in3, busy, done, table_bits, mismatch, pass, pass_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through rows 000..111, holds each row SETTLE_CYCLES cycles,
// samples the gate output, and grades the 8-bit truth table against EXPECTED.
module truth_table_sweeper #(
  parameter int         SETTLE_CYCLES = 16,
  parameter int         CNT_W         = 16,
  parameter logic [7:0] EXPECTED      = 8'hCC
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_n;
  logic [2:0]       row, row_n;
  logic [2:0]       stim, stim_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       tbl, tbl_n;
  logic [7:0]       mm, mm_n;
  logic [7:0]       pcnt, pcnt_n;
  logic             pass_q, pass_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      row    <= '0;
      stim   <= '0;
      cnt    <= '0;
      tbl    <= '0;
      mm     <= '0;
      pcnt   <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_n;
      row    <= row_n;
      stim   <= stim_n;
      cnt    <= cnt_n;
      tbl    <= tbl_n;
      mm     <= mm_n;
      pcnt   <= pcnt_n;
      pass_q <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    cnt_n   = cnt;
    tbl_n   = tbl;
    mm_n    = mm;
    pcnt_n  = pcnt;
    pass_n  = pass_q;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          tbl_n   = '0;
          mm_n    = '0;
          pass_n  = 1'b0;
          row_n   = '0;
          cnt_n   = CNT_LD;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort)        state_n = IDLE;
        else if (cnt == '0)   state_n = SAMPLE;
        else                  cnt_n   = cnt - 1'b1;
      end
      SAMPLE: begin
        // Capture happens even when abort lands on this cycle.
        tbl_n[3'd7 - row] = bus.dut_out;
        if (bus.abort) begin
          state_n = IDLE;
        end else if (row == 3'd7) begin
          state_n = DONE;
          mm_n    = tbl_n ^ EXPECTED;
          pass_n  = (tbl_n == EXPECTED);
          if (tbl_n == EXPECTED && pcnt != 8'hFF) pcnt_n = pcnt + 8'd1;
        end else begin
          row_n   = row + 3'd1;
          cnt_n   = CNT_LD;
          state_n = SETTLE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Stimulus is registered from the next-state so it lines up with SETTLE/SAMPLE.
    stim_n = (state_n == SETTLE || state_n == SAMPLE) ? row_n : 3'b000;
  end

  assign bus.in1        = stim[2];
  assign bus.in2        = stim[1];
  assign bus.in3        = stim[0];
  assign bus.busy       = (state == SETTLE) || (state == SAMPLE);
  assign bus.done       = (state == DONE);
  assign bus.table_bits = tbl;
  assign bus.mismatch   = mm;
  assign bus.pass       = pass_q;
  assign bus.pass_count = pcnt;
endmodule
